// File: rtl/icache_axi_rd_bridge.sv
// ICache line-refill responder bridged onto an AXI4 read channel.
//
// Accepts one refill request at a time from the instruction cache, issues a
// single INCR read burst for the aligned line, and streams the R beats back
// to the cache without buffering.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rd_req / rd_rdy          refill request handshake (rd_rdy high only in IDLE)
//   rd_addr                  refill address, sampled on the handshake cycle
//   ret_data/valid/last      returned words, combinational from the R channel
//   arid..arvalid / arready  AXI read address channel
//   rid..rvalid / rready     AXI read data channel
//   bus_err                  sticky: bad RRESP or RLAST/beat-count disagreement
module icache_axi_rd_bridge #(
  parameter logic [3:0]  AXI_ID     = 4'd0,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned LINE_OFF_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  output logic        rd_rdy,
  input  logic [31:0] rd_addr,
  output logic [31:0] ret_data,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam int unsigned      CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_acc;
  logic             beat_err;
  logic             unused_addr_bits;

  // Offset bits are discarded by line alignment.
  assign unused_addr_bits = ^rd_addr[LINE_OFF_W-1:0];

  assign arid     = AXI_ID;
  assign arlen    = 8'(BURST_LEN - 1);
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;
  assign ret_data = rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake-type outputs come straight from the state so that an
  // asynchronous reset drops them in the same instant.
  always_comb begin
    state_nxt = state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    beat_acc  = 1'b0;
    case (state)
      IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) begin
          state_nxt = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = R;
        end
      end
      R: begin
        rready    = 1'b1;
        beat_acc  = rvalid && (rid == AXI_ID);
        ret_valid = beat_acc;
        ret_last  = beat_acc && rlast;
        // Termination follows RLAST even when it disagrees with the count.
        if (beat_acc && rlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RLAST must coincide exactly with the final counted beat.
  assign beat_err = (rresp != 2'b00) || (rlast != (beat_cnt == LAST_CNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr   <= '0;
      beat_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state == IDLE && rd_req) begin
        araddr   <= {rd_addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
        beat_cnt <= '0;
      end
      if (beat_acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_err) begin
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge.
//
// Each refill is described as a list of R-channel beats; expected outputs are
// derived per cycle from the transaction description (request cycle, address
// wait cycles, beat list) and compared by a single negedge process.
module tb_icache_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_rdy;
  logic [31:0] rd_addr = '0;
  logic [31:0] ret_data;
  logic        ret_valid;
  logic        ret_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        bus_err;

  always #5 clk = ~clk;

  icache_axi_rd_bridge #(
    .AXI_ID     (4'd0),
    .BURST_LEN  (8),
    .LINE_OFF_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_rdy    (rd_rdy),
    .rd_addr   (rd_addr),
    .ret_data  (ret_data),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .bus_err   (bus_err)
  );

  int total = 0;
  int bad   = 0;

  bit          chk_en = 1'b0;
  bit          model_err = 1'b0;
  logic        exp_rd_rdy, exp_arvalid, exp_rready;
  logic        exp_ret_valid, exp_ret_last, exp_bus_err;
  logic [31:0] exp_araddr, exp_ret_data;

  // Beat script for the next refill.
  int          nb;
  logic        bv  [64];
  logic [3:0]  bid [64];
  logic [31:0] bd  [64];
  logic [1:0]  brs [64];
  logic        bl  [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_rdy", rd_rdy, exp_rd_rdy);
      chk("arvalid", arvalid, exp_arvalid);
      chk("rready", rready, exp_rready);
      chk("ret_valid", ret_valid, exp_ret_valid);
      chk("ret_last", ret_last, exp_ret_last);
      chk("bus_err", bus_err, exp_bus_err);
      if (exp_arvalid) begin
        chk("araddr", araddr, exp_araddr);
        chk("arid", arid, 32'd0);
        chk("arlen", arlen, 32'd7);
        chk("arsize", arsize, 32'd2);
        chk("arburst", arburst, 32'd1);
      end
      if (exp_ret_valid) begin
        chk("ret_data", ret_data, exp_ret_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp_idle();
    exp_rd_rdy    = 1'b1;
    exp_arvalid   = 1'b0;
    exp_rready    = 1'b0;
    exp_ret_valid = 1'b0;
    exp_ret_last  = 1'b0;
    exp_bus_err   = model_err;
  endtask

  task automatic add_beat(input logic v, input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] rs, input logic l);
    bv[nb]  = v;
    bid[nb] = id;
    bd[nb]  = d;
    brs[nb] = rs;
    bl[nb]  = l;
    nb++;
  endtask

  // nacc good beats, RLAST on the final one; resp_at marks a SLVERR beat.
  // gaps: 0 none, 1 random idle/foreign beats, 2 alternating idle with one rid=3 beat.
  task automatic build(input int nacc, input int resp_at, input int gaps, input bit lit);
    nb = 0;
    for (int a = 0; a < nacc; a++) begin
      if (gaps == 1) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          if ($urandom_range(0, 1) == 1)
            add_beat(1'b1, 4'($urandom_range(1, 15)), $urandom, 2'($urandom), 1'($urandom));
          else
            add_beat(1'b0, 4'd0, $urandom, 2'b00, 1'($urandom));
        end
      end else if (gaps == 2 && a > 0) begin
        add_beat(1'b0, 4'd0, $urandom, 2'b00, 1'b0);
        if (a == 4) add_beat(1'b1, 4'd3, $urandom, 2'b00, 1'b0);
      end
      add_beat(1'b1, 4'd0, lit ? 32'h100 + a : $urandom,
               (a == resp_at) ? 2'b10 : 2'b00, a == nacc - 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rd_req  = 1'b0;
      rd_addr = $urandom;
      arready = 1'($urandom);
      rvalid  = 1'($urandom);
      rid     = 4'd0;
      rlast   = 1'($urandom);
      rdata   = $urandom;
      set_exp_idle();
      step();
    end
    rvalid = 1'b0;
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    rd_req  = 1'b0;
    rvalid  = 1'b0;
    arready = 1'b0;
    #2 rst = 1'b0;
    model_err = 1'b0;
    step();
    rst = 1'b1;
    set_exp_idle();
    chk_en = 1'b1;
  endtask

  // Entered and left at posedge+1 with the bridge idle.
  task automatic run_refill(input logic [31:0] addr, input int ar_delay, input bit busy,
                            input bit lit, input int abort_after);
    int acc;
    bit done;
    bit e;
    rd_req  = 1'b1;
    rd_addr = addr;
    arready = 1'b0;
    rvalid  = 1'b0;
    set_exp_idle();
    step();
    for (int d = 0; d <= ar_delay; d++) begin
      rd_req        = busy;
      rd_addr       = $urandom;
      arready       = (d == ar_delay);
      rvalid        = 1'b0;
      exp_rd_rdy    = 1'b0;
      exp_arvalid   = 1'b1;
      exp_rready    = 1'b0;
      exp_ret_valid = 1'b0;
      exp_ret_last  = 1'b0;
      exp_bus_err   = model_err;
      exp_araddr    = {addr[31:5], 5'b0};
      if (lit && d == 0) begin
        #3 chk("lit_araddr", araddr, 32'h1C00_0020);
      end
      step();
    end
    acc  = 0;
    done = 1'b0;
    for (int i = 0; i < nb && !done; i++) begin
      rd_req        = busy;
      rd_addr       = $urandom;
      arready       = 1'($urandom);
      rvalid        = bv[i];
      rid           = bid[i];
      rdata         = bd[i];
      rresp         = brs[i];
      rlast         = bl[i];
      exp_rd_rdy    = 1'b0;
      exp_arvalid   = 1'b0;
      exp_rready    = 1'b1;
      exp_bus_err   = model_err;
      exp_ret_valid = bv[i] && (bid[i] == 4'd0);
      exp_ret_last  = exp_ret_valid && bl[i];
      exp_ret_data  = bd[i];
      e = 1'b0;
      // Beat counter is 3 bits wide; last counted beat is index 7 mod 8.
      if (exp_ret_valid)
        e = (brs[i] != 2'b00) || (bl[i] != ((acc % 8) == 7));
      if (abort_after != 0 && exp_ret_valid && acc == abort_after) begin
        chk_en = 1'b0;
        #1;
        chk("pre_rst_ret_valid", ret_valid, 32'd1);
        chk("pre_rst_bus_err", bus_err, model_err);
        #1 rst = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 32'd0);
        chk("rst_rready", rready, 32'd0);
        chk("rst_ret_valid", ret_valid, 32'd0);
        chk("rst_ret_last", ret_last, 32'd0);
        chk("rst_bus_err", bus_err, 32'd0);
        chk("rst_rd_rdy", rd_rdy, 32'd1);
        rvalid    = 1'b0;
        rd_req    = 1'b0;
        model_err = 1'b0;
        step();
        rst = 1'b1;
        set_exp_idle();
        chk_en = 1'b1;
        return;
      end
      if (lit && exp_ret_valid) begin
        #1;
        chk("lit_ret_data", ret_data, 32'h100 + acc);
        chk("lit_ret_last", ret_last, acc == 7);
      end
      step();
      if (exp_ret_valid) begin
        if (e) model_err = 1'b1;
        if (bl[i]) done = 1'b1;
        acc++;
      end
    end
    rvalid = 1'b0;
    if (!busy) rd_req = 1'b0;
    set_exp_idle();
    if (lit) begin
      #1;
      chk("lit_rd_rdy_after", rd_rdy, 32'd1);
      chk("lit_bus_err_clean", bus_err, 32'd0);
    end
  endtask

  initial begin
    #2;
    chk("reset_arvalid", arvalid, 32'd0);
    chk("reset_rready", rready, 32'd0);
    chk("reset_ret_valid", ret_valid, 32'd0);
    chk("reset_ret_last", ret_last, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_bus_err", bus_err, 32'd0);
    step();
    rst = 1'b1;
    set_exp_idle();
    chk_en = 1'b1;
    #1 chk("reset_rd_rdy", rd_rdy, 32'd1);
    idle(2);

    // Basic refill with known data.
    build(8, -1, 0, 1'b1);
    run_refill(32'h1C00_0034, 0, 1'b0, 1'b1, 0);
    idle(2);

    // Address-channel backpressure.
    build(8, -1, 0, 1'b0);
    run_refill($urandom, 5, 1'b0, 1'b0, 0);
    idle(1);

    // R gaps and a foreign-ID beat.
    build(8, -1, 2, 1'b0);
    run_refill($urandom, 1, 1'b0, 1'b0, 0);
    idle(1);

    // Early RLAST on the 6th beat, then a clean refill keeps the flag.
    build(6, -1, 0, 1'b0);
    run_refill($urandom, 0, 1'b0, 1'b0, 0);
    idle(1);
    chk("early_rlast_bus_err", bus_err, 32'd1);
    build(8, -1, 1, 1'b0);
    run_refill($urandom, 2, 1'b0, 1'b0, 0);
    idle(1);
    chk("sticky_bus_err", bus_err, 32'd1);

    // Error response on beat 3.
    do_reset();
    build(8, 2, 0, 1'b0);
    run_refill($urandom, 0, 1'b0, 1'b0, 0);
    idle(1);
    chk("rresp_bus_err", bus_err, 32'd1);

    // Request held while busy with a changing address.
    do_reset();
    build(8, -1, 1, 1'b0);
    run_refill($urandom, 1, 1'b1, 1'b0, 0);
    build(8, -1, 0, 1'b0);
    run_refill($urandom, 0, 1'b0, 1'b0, 0);
    idle(2);

    // Asynchronous reset after the 4th beat, then a normal refill.
    build(8, 2, 0, 1'b0);
    run_refill($urandom, 0, 1'b0, 1'b0, 4);
    build(8, -1, 1, 1'b0);
    run_refill($urandom, 1, 1'b0, 1'b0, 0);
    idle(2);

    // Randomised refills.
    for (int t = 0; t < 40; t++) begin
      int mode;
      int nacc;
      bit busy;
      if (model_err && $urandom_range(0, 2) == 0) do_reset();
      mode = $urandom_range(0, 4);
      nacc = (mode == 2) ? $urandom_range(1, 7) : (mode == 3) ? $urandom_range(9, 11) : 8;
      busy = ($urandom_range(0, 2) == 0);
      build(nacc, (mode == 4) ? $urandom_range(0, 7) : -1, $urandom_range(0, 1), 1'b0);
      run_refill($urandom, $urandom_range(0, 4), busy, 1'b0, 0);
      if (!busy) idle($urandom_range(0, 3));
    end
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
